// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle sequencing controller: fetch, decode, execute, memory and write-back stepping.
// Define CPU_SEQ_TRAP_EN to build illegal-opcode trapping; otherwise illegal opcodes run as NOPs.
module cpu_seq_ctrl #(
    parameter logic [31:0] TRAP_VEC = 32'h0000_0020
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    input  logic        zero_flag,
    input  logic        lt_flag,
    output logic [1:0]  alu_op,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic        rf_wsel,
    output logic        trap,
    output logic [2:0]  state_dbg
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_BR   = 6'h06;
    localparam logic [5:0] OP_BEQ  = 6'h26;
    localparam logic [5:0] OP_BLT  = 6'h16;
    localparam logic [5:0] OP_ADDI = 6'h04;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h14;
    localparam logic [5:0] OP_LDW  = 6'h17;
    localparam logic [5:0] OP_STW  = 6'h15;

    logic [2:0] state;
    logic [2:0] next_state;
    logic       taken_q;
    logic [5:0] opcode;
    logic       is_br, is_beq, is_blt, is_branch;
    logic       is_addi, is_andi, is_ori, is_alu_imm;
    logic       is_ldw, is_stw, is_illegal;
    logic       trap_hit;
    logic       exec_load;

    assign opcode     = inst_out[5:0];
    assign is_br      = (opcode == OP_BR);
    assign is_beq     = (opcode == OP_BEQ);
    assign is_blt     = (opcode == OP_BLT);
    assign is_branch  = is_br | is_beq | is_blt;
    assign is_addi    = (opcode == OP_ADDI);
    assign is_andi    = (opcode == OP_ANDI);
    assign is_ori     = (opcode == OP_ORI);
    assign is_alu_imm = is_addi | is_andi | is_ori;
    assign is_ldw     = (opcode == OP_LDW);
    assign is_stw     = (opcode == OP_STW);
    assign is_illegal = ~(is_branch | is_alu_imm | is_ldw | is_stw);

`ifdef CPU_SEQ_TRAP_EN
    // The PC mux picks TRAP_VEC whenever trap is high, so trap rides with pc_load.
    assign trap_hit = is_illegal;
`else
    assign trap_hit = 1'b0;
`endif

    always_comb begin
        alu_op = 2'b00;
        if (is_branch)
            alu_op = 2'b01;
        else if (is_andi)
            alu_op = 2'b10;
        else if (is_ori)
            alu_op = 2'b11;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:  next_state = imem_ack ? S_DECODE : S_FETCH;
            S_DECODE: next_state = S_EXEC;
            S_EXEC: begin
                if (is_alu_imm)
                    next_state = S_WB;
                else if (is_ldw || is_stw)
                    next_state = S_MEM;
                else
                    next_state = S_FETCH;
            end
            S_MEM: begin
                if (!dmem_ack)
                    next_state = S_MEM;
                else if (is_ldw)
                    next_state = S_WB;
                else
                    next_state = S_FETCH;
            end
            S_WB:     next_state = S_FETCH;
            default:  next_state = S_FETCH;
        endcase
    end

    // Branch outcome is captured at the end of DECODE so EXEC strobes come straight from flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_FETCH;
            inst_out <= 32'd0;
            taken_q  <= 1'b0;
        end else begin
            state <= next_state;
            if (state == S_FETCH && imem_ack)
                inst_out <= imem_rdata;
            if (state == S_DECODE)
                taken_q <= is_br | (is_beq & zero_flag) | (is_blt & lt_flag);
        end
    end

    assign exec_load = is_branch ? taken_q : trap_hit;

    assign imem_req  = (state == S_FETCH);
    assign pc_load   = (state == S_EXEC) & exec_load;
    assign pc_inc    = (state == S_EXEC) & ~exec_load;
    assign trap      = (state == S_EXEC) & trap_hit;
    assign dmem_req  = (state == S_MEM);
    assign dmem_we   = (state == S_MEM) & is_stw;
    assign rf_we     = (state == S_WB);
    assign rf_wsel   = (state == S_WB) & is_ldw;
    assign state_dbg = state;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Table-driven bench for cpu_seq_ctrl: one record per clock cycle, plus a fetch wait-state sequence.
// Honours CPU_SEQ_TRAP_EN when choosing the expected illegal-opcode behaviour.
module tb_cpu_seq_ctrl;

`ifdef CPU_SEQ_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [31:0] I_ADDI = 32'h1111_1104;
    localparam logic [31:0] I_BLT1 = 32'h2222_2216;
    localparam logic [31:0] I_BLT2 = 32'h3333_3316;
    localparam logic [31:0] I_LDW  = 32'h4444_4417;
    localparam logic [31:0] I_STW  = 32'h5555_5515;
    localparam logic [31:0] I_ILL  = 32'h6666_663F;
    localparam logic [31:0] I_ANDI = 32'h7777_770C;
    localparam logic [31:0] I_ORI  = 32'h8888_8814;
    localparam logic [31:0] I_BEQ  = 32'h9999_9926;
    localparam logic [31:0] I_BR   = 32'hAAAA_AA06;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst_out;
    logic        zero_flag;
    logic        lt_flag;
    logic [1:0]  alu_op;
    logic        pc_inc;
    logic        pc_load;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        rf_we;
    logic        rf_wsel;
    logic        trap;
    logic [2:0]  state_dbg;

    int errors = 0;
    int checks = 0;

    cpu_seq_ctrl dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_out(inst_out), .zero_flag(zero_flag), .lt_flag(lt_flag),
        .alu_op(alu_op), .pc_inc(pc_inc), .pc_load(pc_load),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .trap(trap), .state_dbg(state_dbg)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        iack;
        logic [31:0] idata;
        logic        z;
        logic        lt;
        logic        dack;
        logic [2:0]  st;
        logic        ireq;
        logic        inc;
        logic        ld;
        logic        dreq;
        logic        dwe;
        logic        rfwe;
        logic        wsel;
        logic        trp;
        logic [1:0]  alu;
        logic [31:0] inst;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic iack, input logic [31:0] idata,
        input logic z, input logic lt, input logic dack,
        input logic [2:0] st, input logic ireq, input logic inc, input logic ld,
        input logic dreq, input logic dwe, input logic rfwe, input logic wsel,
        input logic trp, input logic [1:0] alu, input logic [31:0] inst);
        vec_t v;
        v.rst = rst;   v.iack = iack; v.idata = idata;
        v.z = z;       v.lt = lt;     v.dack = dack;
        v.st = st;     v.ireq = ireq; v.inc = inc;   v.ld = ld;
        v.dreq = dreq; v.dwe = dwe;   v.rfwe = rfwe; v.wsel = wsel;
        v.trp = trp;   v.alu = alu;   v.inst = inst;
        return v;
    endfunction

    task automatic checkOne(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset      = v.rst;
        imem_ack   = v.iack;
        imem_rdata = v.idata;
        zero_flag  = v.z;
        lt_flag    = v.lt;
        dmem_ack   = v.dack;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkOne("state_dbg", idx, {29'd0, state_dbg}, {29'd0, v.st});
        checkOne("imem_req",  idx, {31'd0, imem_req},  {31'd0, v.ireq});
        checkOne("pc_inc",    idx, {31'd0, pc_inc},    {31'd0, v.inc});
        checkOne("pc_load",   idx, {31'd0, pc_load},   {31'd0, v.ld});
        checkOne("dmem_req",  idx, {31'd0, dmem_req},  {31'd0, v.dreq});
        checkOne("dmem_we",   idx, {31'd0, dmem_we},   {31'd0, v.dwe});
        checkOne("rf_we",     idx, {31'd0, rf_we},     {31'd0, v.rfwe});
        checkOne("rf_wsel",   idx, {31'd0, rf_wsel},   {31'd0, v.wsel});
        checkOne("trap",      idx, {31'd0, trap},      {31'd0, v.trp});
        checkOne("alu_op",    idx, {30'd0, alu_op},    {30'd0, v.alu});
        checkOne("inst_out",  idx, inst_out,           v.inst);
    endtask

    initial begin
        int pulses;
        int cyc;
        bit done;

        // Inputs for the cycle, then what the outputs must show during that cycle.
        //                rst iack idata  z  lt dack  st  ireq inc ld dreq dwe rfwe wsel trp alu    inst
        vecs.push_back(mk(1, 0, 32'd0,  0, 0, 0,   0,  1,  0,  0,  0,  0,  0,  0,  0,  2'b00, 32'd0));
        vecs.push_back(mk(0, 1, I_ADDI, 0, 0, 0,   0,  1,  0,  0,  0,  0,  0,  0,  0,  2'b00, 32'd0));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   1,  0,  0,  0,  0,  0,  0,  0,  0,  2'b00, I_ADDI));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   2,  0,  1,  0,  0,  0,  0,  0,  0,  2'b00, I_ADDI));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   4,  0,  0,  0,  0,  0,  1,  0,  0,  2'b00, I_ADDI));
        vecs.push_back(mk(0, 1, I_BLT1, 0, 1, 0,   0,  1,  0,  0,  0,  0,  0,  0,  0,  2'b00, I_ADDI));
        vecs.push_back(mk(0, 0, 32'd0,  0, 1, 0,   1,  0,  0,  0,  0,  0,  0,  0,  0,  2'b01, I_BLT1));
        vecs.push_back(mk(0, 0, 32'd0,  0, 1, 0,   2,  0,  0,  1,  0,  0,  0,  0,  0,  2'b01, I_BLT1));
        vecs.push_back(mk(0, 1, I_BLT2, 0, 0, 0,   0,  1,  0,  0,  0,  0,  0,  0,  0,  2'b01, I_BLT1));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   1,  0,  0,  0,  0,  0,  0,  0,  0,  2'b01, I_BLT2));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   2,  0,  1,  0,  0,  0,  0,  0,  0,  2'b01, I_BLT2));
        vecs.push_back(mk(0, 1, I_LDW,  0, 0, 0,   0,  1,  0,  0,  0,  0,  0,  0,  0,  2'b01, I_BLT2));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   1,  0,  0,  0,  0,  0,  0,  0,  0,  2'b00, I_LDW));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   2,  0,  1,  0,  0,  0,  0,  0,  0,  2'b00, I_LDW));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   3,  0,  0,  0,  1,  0,  0,  0,  0,  2'b00, I_LDW));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   3,  0,  0,  0,  1,  0,  0,  0,  0,  2'b00, I_LDW));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   3,  0,  0,  0,  1,  0,  0,  0,  0,  2'b00, I_LDW));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 1,   3,  0,  0,  0,  1,  0,  0,  0,  0,  2'b00, I_LDW));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   4,  0,  0,  0,  0,  0,  1,  1,  0,  2'b00, I_LDW));
        vecs.push_back(mk(0, 1, I_STW,  0, 0, 0,   0,  1,  0,  0,  0,  0,  0,  0,  0,  2'b00, I_LDW));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   1,  0,  0,  0,  0,  0,  0,  0,  0,  2'b00, I_STW));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   2,  0,  1,  0,  0,  0,  0,  0,  0,  2'b00, I_STW));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 1,   3,  0,  0,  0,  1,  1,  0,  0,  0,  2'b00, I_STW));
        vecs.push_back(mk(0, 1, I_ILL,  0, 0, 0,   0,  1,  0,  0,  0,  0,  0,  0,  0,  2'b00, I_STW));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   1,  0,  0,  0,  0,  0,  0,  0,  0,  2'b00, I_ILL));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   2,  0, !TRAP_EN, TRAP_EN, 0, 0, 0, 0, TRAP_EN, 2'b00, I_ILL));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 1,   0,  1,  0,  0,  0,  0,  0,  0,  0,  2'b00, I_ILL));
        vecs.push_back(mk(0, 1, I_ANDI, 0, 0, 0,   0,  1,  0,  0,  0,  0,  0,  0,  0,  2'b00, I_ILL));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   1,  0,  0,  0,  0,  0,  0,  0,  0,  2'b10, I_ANDI));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   2,  0,  1,  0,  0,  0,  0,  0,  0,  2'b10, I_ANDI));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   4,  0,  0,  0,  0,  0,  1,  0,  0,  2'b10, I_ANDI));
        vecs.push_back(mk(0, 1, I_ORI,  0, 0, 0,   0,  1,  0,  0,  0,  0,  0,  0,  0,  2'b10, I_ANDI));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   1,  0,  0,  0,  0,  0,  0,  0,  0,  2'b11, I_ORI));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   2,  0,  1,  0,  0,  0,  0,  0,  0,  2'b11, I_ORI));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   4,  0,  0,  0,  0,  0,  1,  0,  0,  2'b11, I_ORI));
        vecs.push_back(mk(0, 1, I_BEQ,  0, 0, 0,   0,  1,  0,  0,  0,  0,  0,  0,  0,  2'b11, I_ORI));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   1,  0,  0,  0,  0,  0,  0,  0,  0,  2'b01, I_BEQ));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   2,  0,  1,  0,  0,  0,  0,  0,  0,  2'b01, I_BEQ));
        vecs.push_back(mk(0, 1, I_BR,   0, 0, 0,   0,  1,  0,  0,  0,  0,  0,  0,  0,  2'b01, I_BEQ));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   1,  0,  0,  0,  0,  0,  0,  0,  0,  2'b01, I_BR));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   2,  0,  0,  1,  0,  0,  0,  0,  0,  2'b01, I_BR));
        vecs.push_back(mk(0, 1, I_LDW,  0, 0, 0,   0,  1,  0,  0,  0,  0,  0,  0,  0,  2'b01, I_BR));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   1,  0,  0,  0,  0,  0,  0,  0,  0,  2'b00, I_LDW));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   2,  0,  1,  0,  0,  0,  0,  0,  0,  2'b00, I_LDW));
        vecs.push_back(mk(1, 0, 32'd0,  0, 0, 0,   3,  0,  0,  0,  1,  0,  0,  0,  0,  2'b00, I_LDW));
        vecs.push_back(mk(0, 0, 32'd0,  0, 0, 0,   0,  1,  0,  0,  0,  0,  0,  0,  0,  2'b00, 32'd0));

        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        zero_flag  = 1'b0;
        lt_flag    = 1'b0;
        dmem_ack   = 1'b0;
        @(posedge clock);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clock);
            applyStimulus(vecs[i]);
            #1;
            checkOutput(vecs[i], i);
        end

        // Fetch with two wait cycles, then count PC pulses until the ORI retires.
        @(negedge clock);
        imem_ack = 1'b0;
        #1;
        checkOne("wait1_state", 0, {29'd0, state_dbg}, 32'd0);
        @(negedge clock);
        #1;
        checkOne("wait2_state", 0, {29'd0, state_dbg}, 32'd0);
        checkOne("wait2_inst", 0, inst_out, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = I_ORI;
        @(negedge clock);
        imem_ack = 1'b0;
        #1;
        checkOne("wait_decode_state", 0, {29'd0, state_dbg}, 32'd1);
        checkOne("wait_decode_inst", 0, inst_out, I_ORI);

        pulses = 0;
        cyc    = 0;
        done   = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clock);
            #1;
            cyc++;
            pulses += int'(pc_inc) + int'(pc_load);
            if (state_dbg == 3'd0)
                done = 1'b1;
        end
        checkOne("retire_reached", 0, {31'd0, done}, 32'd1);
        checkOne("retire_cycles", 0, cyc, 32'd3);
        checkOne("retire_pc_pulses", 0, pulses, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_seq_ctrl.md
# cpu_seq_ctrl

Multi-cycle sequencing controller for the NIOS II-subset core. It fetches each instruction over the instruction-memory handshake and holds it in the instruction register (`inst_out`). It decodes `inst_out[5:0]` and steps the instruction through EXEC, MEM and WB states. It issues exactly one program-counter update per instruction: either an increment or a branch-target load. It also drives ALU, data-memory and register-file strobes.

## Interface
- `TRAP_VEC` — default 32'h0000_0020 — exception vector, used only when the trap feature is compiled in
- `clock` in 1 — rising-edge clock
- `reset` in 1 — reset, synchronous, active-high
- `imem_req` out 1 — instruction fetch request
- `imem_ack` in 1 — fetch data valid
- `imem_rdata` in 32 — fetched instruction
- `inst_out` out 32 — instruction register
- `zero_flag` in 1 — ALU result == 0
- `lt_flag` in 1 — ALU signed A < B
- `alu_op` out 2 — 00 add, 01 sub/compare, 10 and, 11 or
- `pc_inc` out 1 — one-cycle pulse: PC <= PC + 4
- `pc_load` out 1 — one-cycle pulse: PC <= target
- `dmem_req` out 1 — data access request
- `dmem_we` out 1 — 1 = store
- `dmem_ack` in 1 — data access complete
- `rf_we` out 1 — register-file write strobe
- `rf_wsel` out 1 — write-data source: 0 = ALU, 1 = memory
- `trap` out 1 — illegal-opcode pulse (trap feature only)
- `state_dbg` out 3 — current state encoding

## Operation
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Encodings 5–7 are unreachable and recover to FETCH.
- Opcode classes, decoded from `inst_out[5:0]`:
  - Branches: br 0x06 always taken; beq 0x26 taken if `zero_flag`; blt 0x16 taken if `lt_flag`.
  - ALU immediates: addi 0x04 (add), andi 0x0C (and), ori 0x14 (or).
  - Loads and stores: ldw 0x17, stw 0x15. Both use add for address generation.
  - Anything else is illegal.
- FETCH:
  - `imem_req`=1 while in this state.
  - On the edge where `imem_ack`=1: `inst_out` <= `imem_rdata`, go to DECODE.
- DECODE: one cycle, operand read. `alu_op` is valid from DECODE through WB.
- EXEC: exactly one of `pc_inc` / `pc_load` is 1 for this one cycle.
  - Branch: `pc_load`=1 if taken, else `pc_inc`=1; next state FETCH.
  - ALU-immediate: `pc_inc`=1; next state WB.
  - ldw/stw: `pc_inc`=1; next state MEM.
  - Branch compares use `alu_op`=01.
- MEM:
  - `dmem_req`=1; `dmem_we`=1 for stw.
  - On `dmem_ack`: ldw goes to WB, stw goes to FETCH.
- WB: `rf_we`=1 for one cycle; `rf_wsel`=1 for ldw; next state FETCH.
- Outputs are a decode of the registered state, so there are no combinational paths from any input to any output.
- Reset values: state FETCH, `inst_out`=0, `alu_op`=00. `pc_inc`, `pc_load`, `dmem_req`, `dmem_we`, `rf_we`, `rf_wsel` and `trap` are all 0. `imem_req`=1, because FETCH is the reset state.

## Timing
- `imem_ack` may be high in the first FETCH cycle; FETCH then lasts 1 cycle. Each extra wait cycle adds one cycle.
- Instruction latency with zero-wait memory:
  - branch: 3 cycles
  - ALU-immediate: 4 cycles
  - stw: 4 cycles
  - ldw: 5 cycles
- Per instruction, `pc_inc` + `pc_load` pulse exactly once in total. The PC is never updated in FETCH, MEM or WB.
- Acks arriving outside the matching state are ignored.
- Reset in any state, including mid-handshake, takes effect at the next edge: state FETCH, strobes low. A pending memory access is abandoned.
- `inst_out` changes only on an accepted fetch.

## Configuration
- `CPU_SEQ_TRAP_EN` defined:
  - An illegal opcode in EXEC pulses `trap`=1 and `pc_load`=1, with the target forced to `TRAP_VEC`. The PC mux selects the vector when `trap`=1.
  - Next state FETCH.
- Undefined:
  - `trap` is tied 0, and illegal opcodes execute as a NOP: `pc_inc`=1 in EXEC, then FETCH.

## Test plan
- Reset held 2 cycles, then released, zero-wait memory → `imem_req`=1 in the first cycle and `state_dbg` sequence 0,1,2,4,0 for addi. The EXEC cycle shows `pc_inc`=1 and `alu_op`=00; the WB cycle shows `rf_we`=1.
- blt with `lt_flag`=1, then blt with `lt_flag`=0 → the first has `pc_load`=1 in EXEC, the second `pc_inc`=1. Each takes 3 cycles.
- ldw with `dmem_ack` delayed 3 cycles → `dmem_req` held high for 4 cycles with `dmem_we`=0, then WB with `rf_wsel`=1. No second PC pulse.
- stw with zero-wait memory → `dmem_we`=1 for one MEM cycle, then return to FETCH; `rf_we` never asserts.
- `reset` asserted during MEM of ldw → next cycle: FETCH, `dmem_req`=0, `inst_out`=0.
- Opcode 0x3F:
  - With `CPU_SEQ_TRAP_EN`: `trap`=1 and `pc_load`=1 for one cycle.
  - Without it: `pc_inc`=1 and `trap`=0.
